lane_sweep_ctrl: RTL and testbench

- Parametrised sequencer that sweeps a ROWS x COLS lane matrix through the read / rotate / arithmetic / write-back datapath of the permutation engine, for NROUNDS rounds per start.
- Generalises the earlier fixed 5x5 row controller:
  - configurable geometry, memory read latency and round count;
  - per-lane variable rotation count;
  - three arithmetic modes;
  - abort input and explicit busy/done handshake.
- Sits between the top-level start logic and the lane memory / shifter / ALU datapath.

---
 rtl/lane_sweep_ctrl.sv | 160 ++++++++++++++++
 tb/tb_lane_sweep_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_sweep_ctrl.sv
// lane_sweep_ctrl: walks a ROWS x COLS lane matrix through read, rotate,
// ALU and write-back for NROUNDS rounds per start, with abort and done.
module lane_sweep_ctrl #(
  parameter int ROWS    = 5,
  parameter int COLS    = 5,
  parameter int SHW     = 5,
  parameter int RD_LAT  = 1,
  parameter int NROUNDS = 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int NW = $clog2(NROUNDS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [SHW-1:0] shamt,
  output logic [RW-1:0] row_idx,
  output logic [CW-1:0] col_idx,
  output logic [NW-1:0] round_idx,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          shift_en,
  output logic          alu_en,
  output logic          alu_op,
  output logic          acc_clr,
  output logic          busy,
  output logic          done
);

  typedef enum logic [3:0] {
    IDLE, ROW_INIT, RD, WAIT, SHIFT, ALU1, ALU2,
    WR, NEXT_ROW, NEXT_ROUND, DONE
  } state_t;

  state_t         state, st_n, rot_next;
  logic [1:0]     mode_q, mode_n;
  logic [1:0]     lat_cnt, lat_n;
  logic [SHW-1:0] sh_cnt, sh_n;
  logic [RW-1:0]  row_n;
  logic [CW-1:0]  col_n;
  logic [NW-1:0]  rnd_n;

  // Rotate-only lanes bypass the ALU states entirely.
  always_comb begin
    rot_next = (mode_q == 2'd0) ? WR : ALU1;
    st_n   = state;
    row_n  = row_idx;
    col_n  = col_idx;
    rnd_n  = round_idx;
    mode_n = mode_q;
    lat_n  = lat_cnt;
    sh_n   = sh_cnt;
    if (state != IDLE && abort) begin
      st_n  = IDLE;
      row_n = '0;
      col_n = '0;
      rnd_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            mode_n = (mode == 2'd3) ? 2'd0 : mode;
            row_n  = '0;
            col_n  = '0;
            rnd_n  = '0;
            st_n   = ROW_INIT;
          end
        end
        ROW_INIT: st_n = RD;
        RD: begin
          lat_n = 2'(RD_LAT - 1);
          st_n  = WAIT;
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            sh_n = shamt;
            st_n = (shamt != '0) ? SHIFT : rot_next;
          end else begin
            lat_n = lat_cnt - 2'd1;
          end
        end
        SHIFT: begin
          if (sh_cnt == SHW'(1)) st_n = rot_next;
          else sh_n = sh_cnt - SHW'(1);
        end
        ALU1: st_n = (mode_q == 2'd2) ? ALU2 : WR;
        ALU2: st_n = WR;
        WR: begin
          if (col_idx != CW'(COLS - 1)) begin
            col_n = col_idx + CW'(1);
            st_n  = RD;
          end else begin
            col_n = '0;
            st_n  = NEXT_ROW;
          end
        end
        NEXT_ROW: begin
          if (row_idx != RW'(ROWS - 1)) begin
            row_n = row_idx + RW'(1);
            st_n  = ROW_INIT;
          end else begin
            row_n = '0;
            st_n  = NEXT_ROUND;
          end
        end
        NEXT_ROUND: begin
          if (round_idx != NW'(NROUNDS - 1)) begin
            rnd_n = round_idx + NW'(1);
            st_n  = ROW_INIT;
          end else begin
            rnd_n = '0;
            st_n  = DONE;
          end
        end
        DONE: st_n = IDLE;
        default: st_n = IDLE;
      endcase
    end
  end

  // Strobes are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mode_q    <= 2'd0;
      lat_cnt   <= 2'd0;
      sh_cnt    <= '0;
      row_idx   <= '0;
      col_idx   <= '0;
      round_idx <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      shift_en  <= 1'b0;
      alu_en    <= 1'b0;
      alu_op    <= 1'b0;
      acc_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= st_n;
      mode_q    <= mode_n;
      lat_cnt   <= lat_n;
      sh_cnt    <= sh_n;
      row_idx   <= row_n;
      col_idx   <= col_n;
      round_idx <= rnd_n;
      mem_rd    <= (st_n == RD);
      mem_wr    <= (st_n == WR);
      shift_en  <= (st_n == SHIFT);
      alu_en    <= (st_n == ALU1) || (st_n == ALU2);
      alu_op    <= (st_n == ALU2);
      acc_clr   <= (st_n == ROW_INIT);
      busy      <= (st_n != IDLE);
      done      <= (st_n == DONE);
    end
  end

endmodule

// File: tb/tb_lane_sweep_ctrl.sv
// tb_lane_sweep_ctrl: cycle-trace scoreboard for two lane_sweep_ctrl
// instances (default geometry, and 2x3 / 2 rounds / RD_LAT=2).
module tb_lane_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_start, a_abort;
  logic [1:0] a_mode;
  logic [4:0] a_shamt;
  logic [2:0] a_row, a_col;
  logic [0:0] a_rnd;
  logic a_rd, a_wr, a_sh, a_alu, a_op, a_clr, a_busy, a_done;

  logic       b_start, b_abort;
  logic [1:0] b_mode;
  logic [4:0] b_shamt;
  logic [0:0] b_row;
  logic [1:0] b_col;
  logic [1:0] b_rnd;
  logic b_rd, b_wr, b_sh, b_alu, b_op, b_clr, b_busy, b_done;

  lane_sweep_ctrl u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .mode(a_mode), .shamt(a_shamt),
    .row_idx(a_row), .col_idx(a_col), .round_idx(a_rnd),
    .mem_rd(a_rd), .mem_wr(a_wr), .shift_en(a_sh),
    .alu_en(a_alu), .alu_op(a_op), .acc_clr(a_clr),
    .busy(a_busy), .done(a_done)
  );

  lane_sweep_ctrl #(
    .ROWS(2), .COLS(3), .SHW(5), .RD_LAT(2), .NROUNDS(2)
  ) u_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .mode(b_mode), .shamt(b_shamt),
    .row_idx(b_row), .col_idx(b_col), .round_idx(b_rnd),
    .mem_rd(b_rd), .mem_wr(b_wr), .shift_en(b_sh),
    .alu_en(b_alu), .alu_op(b_op), .acc_clr(b_clr),
    .busy(b_busy), .done(b_done)
  );

  // Trace word: {busy,done,clr,rd,sh,alu,op,wr, row[4], col[4], rnd[4]}
  localparam logic [7:0] F_DONE = 8'h40;
  localparam logic [7:0] F_CLR  = 8'h20;
  localparam logic [7:0] F_RD   = 8'h10;
  localparam logic [7:0] F_SH   = 8'h08;
  localparam logic [7:0] F_ALU  = 8'h04;
  localparam logic [7:0] F_OP   = 8'h02;
  localparam logic [7:0] F_WR   = 8'h01;

  logic [19:0] qa[$];
  logic [19:0] qb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int na_rd, na_wr, na_sh, na_clr, na_done, da_cyc;
  int nb_wr, nb_clr, nb_done, nb_sh, wr1, gap;

  function automatic logic [19:0] obs_a();
    return {a_busy, a_done, a_clr, a_rd, a_sh, a_alu, a_op, a_wr,
            4'(a_row), 4'(a_col), 4'(a_rnd)};
  endfunction

  function automatic logic [19:0] obs_b();
    return {b_busy, b_done, b_clr, b_rd, b_sh, b_alu, b_op, b_wr,
            4'(b_row), 4'(b_col), 4'(b_rnd)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] f,
                      input int r, input int c, input int n);
    logic [19:0] v;
    v = {8'h80 | f, 4'(r), 4'(c), 4'(n)};
    if (sel == 0) qa.push_back(v);
    else qb.push_back(v);
  endtask

  // Expected per-cycle trace of one full sweep, starting the cycle after start.
  task automatic gen(input int sel, input int rows, input int cols,
                     input int nr, input int lat, input int md,
                     input int sh);
    for (int n = 0; n < nr; n++) begin
      for (int r = 0; r < rows; r++) begin
        push(sel, F_CLR, r, 0, n);
        for (int c = 0; c < cols; c++) begin
          push(sel, F_RD, r, c, n);
          for (int k = 0; k < lat; k++) push(sel, 8'h00, r, c, n);
          for (int k = 0; k < sh; k++) push(sel, F_SH, r, c, n);
          if (md == 1 || md == 2) push(sel, F_ALU, r, c, n);
          if (md == 2) push(sel, F_ALU | F_OP, r, c, n);
          push(sel, F_WR, r, c, n);
        end
        push(sel, 8'h00, r, 0, n);
      end
      push(sel, 8'h00, 0, 0, n);
    end
    push(sel, F_DONE, 0, 0, 0);
  endtask

  task automatic clr_cnt();
    na_rd = 0; na_wr = 0; na_sh = 0; na_clr = 0; na_done = 0;
    da_cyc = 0;
    nb_wr = 0; nb_clr = 0; nb_done = 0; nb_sh = 0; wr1 = 0; gap = 0;
  endtask

  task automatic tick();
    logic [19:0] ea, eb;
    @(posedge clk);
    #1;
    cyc++;
    if (qa.size() > 0) ea = qa.pop_front();
    else ea = '0;
    if (qb.size() > 0) eb = qb.pop_front();
    else eb = '0;
    chk("a_trace", 32'(obs_a()), 32'(ea));
    chk("b_trace", 32'(obs_b()), 32'(eb));
    chk("a_strobe_onehot",
        32'($countones({a_clr, a_rd, a_sh, a_alu, a_wr}) <= 1), 32'd1);
    if (a_rd) na_rd++;
    if (a_wr) na_wr++;
    if (a_sh) na_sh++;
    if (a_clr) na_clr++;
    if (a_done) begin na_done++; da_cyc = cyc; end
    if (b_wr) begin
      if (nb_wr == 0) wr1 = cyc;
      if (nb_wr == 1) gap = cyc - wr1;
      nb_wr++;
    end
    if (b_clr) nb_clr++;
    if (b_sh) nb_sh++;
    if (b_done) nb_done++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < 3000) begin
      tick();
      if (b_done) b_start = 1'b0;
      n++;
    end
    chk("drain_bound", 32'(n < 3000), 32'd1);
  endtask

  initial begin
    int t0, n;
    rst = 1'b0;
    a_start = 0; a_abort = 0; a_mode = 0; a_shamt = 0;
    b_start = 0; b_abort = 0; b_mode = 0; b_shamt = 0;
    clr_cnt();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", 32'(obs_a()), 32'd0);
    chk("reset_b", 32'(obs_b()), 32'd0);
    @(negedge clk) rst = 1'b1;
    tick();

    // Default geometry, rotate only, no shift.
    clr_cnt();
    a_mode = 2'd0; a_shamt = 5'd0; a_start = 1'b1;
    gen(0, 5, 5, 1, 1, 0, 0);
    t0 = cyc;
    tick();
    a_start = 1'b0;
    drain();
    tick();
    chk("t1_rd_count", 32'(na_rd), 32'd25);
    chk("t1_wr_count", 32'(na_wr), 32'd25);
    chk("t1_shift_count", 32'(na_sh), 32'd0);
    chk("t1_clr_count", 32'(na_clr), 32'd5);
    chk("t1_done_count", 32'(na_done), 32'd1);
    chk("t1_done_latency", 32'(da_cyc - t0), 32'(5 * (5 * 3 + 2) + 2));

    // Sub-then-add, shamt 3, RD_LAT 2; start held high, mode changed mid-run.
    clr_cnt();
    b_mode = 2'd2; b_shamt = 5'd3; b_start = 1'b1;
    gen(1, 2, 3, 2, 2, 2, 3);
    tick();
    repeat (5) tick();
    b_mode = 2'd1;
    drain();
    tick();
    chk("t2_lane_period", 32'(gap), 32'd9);
    chk("t2_shift_count", 32'(nb_sh), 32'(12 * 3));
    chk("t2_done_count", 32'(nb_done), 32'd1);

    // Small geometry, xor-accumulate, two rounds.
    clr_cnt();
    b_mode = 2'd1; b_shamt = 5'd0; b_start = 1'b1;
    gen(1, 2, 3, 2, 2, 1, 0);
    tick();
    b_start = 1'b0;
    drain();
    tick();
    chk("t3_clr_count", 32'(nb_clr), 32'd4);
    chk("t3_wr_count", 32'(nb_wr), 32'd12);
    chk("t3_done_count", 32'(nb_done), 32'd1);

    // Mode 3 behaves as rotate only; abort during SHIFT of lane (1,2).
    clr_cnt();
    a_mode = 2'd3; a_shamt = 5'd2; a_start = 1'b1;
    gen(0, 5, 5, 1, 1, 0, 2);
    tick();
    a_start = 1'b0;
    n = 0;
    while (!(a_sh && a_row == 3'd1 && a_col == 3'd2) && n < 500) begin
      tick();
      n++;
    end
    chk("abort_reach_shift", 32'(n < 500), 32'd1);
    a_abort = 1'b1;
    qa.delete();
    tick();
    a_abort = 1'b0;
    repeat (3) tick();
    chk("abort_no_done", 32'(na_done), 32'd0);

    // start and abort together in IDLE: stay idle.
    a_start = 1'b1; a_abort = 1'b1;
    tick();
    tick();
    a_start = 1'b0; a_abort = 1'b0;

    // Fresh start after abort completes a full sweep.
    clr_cnt();
    a_mode = 2'd0; a_shamt = 5'd1; a_start = 1'b1;
    gen(0, 5, 5, 1, 1, 0, 1);
    tick();
    a_start = 1'b0;
    drain();
    tick();
    chk("restart_wr_count", 32'(na_wr), 32'd25);
    chk("restart_done_count", 32'(na_done), 32'd1);

    // Asynchronous reset in ALU2.
    clr_cnt();
    a_mode = 2'd2; a_shamt = 5'd1; a_start = 1'b1;
    gen(0, 5, 5, 1, 1, 2, 1);
    tick();
    a_start = 1'b0;
    n = 0;
    while (!(a_alu && a_op) && n < 500) begin
      tick();
      n++;
    end
    chk("rst_reach_alu2", 32'(n < 500), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_clear", 32'(obs_a()), 32'd0);
    qa.delete();
    @(negedge clk) rst = 1'b1;
    repeat (3) tick();
    chk("rst_no_done", 32'(na_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
